// File: rtl/gpr_wb_queue.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | gpr_wb_queue : in-order write-back queue owning the GPR write port,   |
// |                with pending-write hazard lookup and forwarding.       |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module gpr_wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [4:0]                   in_dst,
    input  logic                         jal_instr,
    input  logic [31:0]                  in_data,
    input  logic                         drain,
    output logic                         regWr,
    output logic [4:0]                   Rw,
    output logic [31:0]                  busW,
    input  logic [4:0]                   Rs,
    input  logic [4:0]                   Rt,
    output logic                         hitA,
    output logic                         hitB,
    output logic [31:0]                  fwdA,
    output logic [31:0]                  fwdB,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] C_DEPTH    = CNT_W'(DEPTH);
    localparam logic [4:0]       C_LINK_REG = 5'd31;

    logic [4:0]       r_dst  [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic [4:0] w_edst;
    logic       w_nonempty;
    logic       w_pop;
    logic       w_store;

    assign w_edst     = jal_instr ? C_LINK_REG : in_dst;
    assign w_nonempty = (r_count != '0);
    assign w_pop      = drain && w_nonempty && !flush && !reset;

    // A full queue still accepts when the head leaves in the same cycle.
    assign in_ready   = !reset && !flush && ((r_count < C_DEPTH) || (drain && w_nonempty));
    assign w_store    = in_valid && in_ready && (w_edst != 5'd0);

    assign regWr = w_pop;
    assign Rw    = w_pop ? r_dst[r_head]  : 5'd0;
    assign busW  = w_pop ? r_data[r_head] : 32'd0;
    assign count = reset ? '0 : r_count;

    // Scan oldest to youngest so the last match is the newest pending write.
    always_comb begin
        logic [PTR_W-1:0] w_idx;
        w_idx = '0;
        hitA  = 1'b0;
        hitB  = 1'b0;
        fwdA  = 32'd0;
        fwdB  = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PTR_W'(i);
            if (!reset && (CNT_W'(i) < r_count)) begin
                if ((Rs != 5'd0) && (r_dst[w_idx] == Rs)) begin
                    hitA = 1'b1;
                    fwdA = r_data[w_idx];
                end
                if ((Rt != 5'd0) && (r_dst[w_idx] == Rt)) begin
                    hitB = 1'b1;
                    fwdB = r_data[w_idx];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_store) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            if (w_store && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_store && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_store) begin
            r_dst[r_tail]  <= w_edst;
            r_data[r_tail] <= in_data;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset) r_count <= C_DEPTH);

endmodule
`default_nettype wire

// File: tb/tb_gpr_wb_queue.sv
`default_nettype none
// Testbench for gpr_wb_queue: directed vector table plus a randomized
// push/drain run checked against a reference FIFO model.
module tb_gpr_wb_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, jal_instr, drain;
    logic [4:0]  in_dst, Rs, Rt, Rw;
    logic [31:0] in_data, busW, fwdA, fwdB;
    logic        in_ready, regWr, hitA, hitB;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gpr_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_dst(in_dst),
        .jal_instr(jal_instr), .in_data(in_data), .drain(drain),
        .regWr(regWr), .Rw(Rw), .busW(busW), .Rs(Rs), .Rt(Rt),
        .hitA(hitA), .hitB(hitB), .fwdA(fwdA), .fwdB(fwdB), .count(count)
    );

    typedef struct {
        logic [31:0] rst, fl, v, dst, jal, data, dr, rs, rt;
        logic [31:0] rdy, wr, rw, bw, ha, fa, hb, fb, cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        reset = 0; flush = 0; in_valid = 0; in_dst = 0; jal_instr = 0;
        in_data = 0; drain = 0; Rs = 0; Rt = 0;
    endtask

    logic [36:0] model[$];

    initial begin
        //               rst fl v dst jal data          dr rs rt | rdy wr rw bw            ha fa            hb fb    cnt
        tbl.push_back('{1, 0, 1, 5, 0, 32'h1,        0, 5, 0,  0, 0, 0, 0,            0, 0,            0, 0,    0});
        tbl.push_back('{1, 0, 0, 0, 0, 0,            0, 0, 0,  0, 0, 0, 0,            0, 0,            0, 0,    0});
        tbl.push_back('{0, 0, 1, 5, 0, 32'hDEADBEEF, 1, 5, 0,  1, 0, 0, 0,            0, 0,            0, 0,    0});
        tbl.push_back('{0, 0, 0, 0, 0, 0,            1, 5, 0,  1, 1, 5, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 0,    1});
        tbl.push_back('{0, 0, 0, 0, 0, 0,            1, 5, 0,  1, 0, 0, 0,            0, 0,            0, 0,    0});
        // forwarding of the youngest write
        tbl.push_back('{0, 0, 1, 7, 0, 32'h11,       0, 0, 0,  1, 0, 0, 0,            0, 0,            0, 0,    0});
        tbl.push_back('{0, 0, 1, 7, 0, 32'h22,       0, 7, 0,  1, 0, 0, 0,            1, 32'h11,       0, 0,    1});
        tbl.push_back('{0, 0, 1, 3, 0, 32'h33,       0, 7, 3,  1, 0, 0, 0,            1, 32'h22,       0, 0,    2});
        tbl.push_back('{0, 0, 0, 0, 0, 0,            0, 7, 3,  1, 0, 0, 0,            1, 32'h22,       1, 32'h33, 3});
        tbl.push_back('{0, 0, 0, 0, 0, 0,            0, 0, 3,  1, 0, 0, 0,            0, 0,            1, 32'h33, 3});
        // backpressure: fill, stall the 5th, then accept it alongside the first pop
        tbl.push_back('{0, 0, 1, 9, 0, 32'h44,       0, 0, 0,  1, 0, 0, 0,            0, 0,            0, 0,    3});
        tbl.push_back('{0, 0, 1, 10, 0, 32'h55,      0, 9, 0,  0, 0, 0, 0,            1, 32'h44,       0, 0,    4});
        tbl.push_back('{0, 0, 1, 10, 0, 32'h55,      1, 7, 0,  1, 1, 7, 32'h11,       1, 32'h22,       0, 0,    4});
        tbl.push_back('{0, 0, 0, 0, 0, 0,            1, 10, 7, 1, 1, 7, 32'h22,       1, 32'h55,       1, 32'h22, 4});
        tbl.push_back('{0, 0, 0, 0, 0, 0,            1, 0, 0,  1, 1, 3, 32'h33,       0, 0,            0, 0,    3});
        tbl.push_back('{0, 0, 0, 0, 0, 0,            1, 0, 0,  1, 1, 9, 32'h44,       0, 0,            0, 0,    2});
        tbl.push_back('{0, 0, 0, 0, 0, 0,            1, 0, 0,  1, 1, 10, 32'h55,      0, 0,            0, 0,    1});
        tbl.push_back('{0, 0, 0, 0, 0, 0,            1, 0, 0,  1, 0, 0, 0,            0, 0,            0, 0,    0});
        // r0 is dropped, jal forces r31
        tbl.push_back('{0, 0, 1, 0, 0, 32'h99,       0, 0, 0,  1, 0, 0, 0,            0, 0,            0, 0,    0});
        tbl.push_back('{0, 0, 0, 0, 0, 0,            1, 0, 0,  1, 0, 0, 0,            0, 0,            0, 0,    0});
        tbl.push_back('{0, 0, 1, 4, 1, 32'h400010,   1, 0, 0,  1, 0, 0, 0,            0, 0,            0, 0,    0});
        tbl.push_back('{0, 0, 0, 0, 0, 0,            1, 31, 4, 1, 1, 31, 32'h400010,  1, 32'h400010,   0, 0,    1});
        tbl.push_back('{0, 0, 0, 0, 0, 0,            0, 0, 0,  1, 0, 0, 0,            0, 0,            0, 0,    0});
        // flush with a result presented
        tbl.push_back('{0, 0, 1, 1, 0, 32'hA1,       0, 0, 0,  1, 0, 0, 0,            0, 0,            0, 0,    0});
        tbl.push_back('{0, 0, 1, 2, 0, 32'hA2,       0, 0, 0,  1, 0, 0, 0,            0, 0,            0, 0,    1});
        tbl.push_back('{0, 0, 1, 3, 0, 32'hA3,       0, 0, 0,  1, 0, 0, 0,            0, 0,            0, 0,    2});
        tbl.push_back('{0, 1, 1, 4, 0, 32'hA4,       1, 0, 0,  0, 0, 0, 0,            0, 0,            0, 0,    3});
        tbl.push_back('{0, 0, 0, 0, 0, 0,            1, 2, 4,  1, 0, 0, 0,            0, 0,            0, 0,    0});
        // reset with drain high
        tbl.push_back('{0, 0, 1, 1, 0, 32'hB1,       0, 0, 0,  1, 0, 0, 0,            0, 0,            0, 0,    0});
        tbl.push_back('{0, 0, 1, 2, 0, 32'hB2,       0, 0, 0,  1, 0, 0, 0,            0, 0,            0, 0,    1});
        tbl.push_back('{0, 0, 1, 3, 0, 32'hB3,       0, 0, 0,  1, 0, 0, 0,            0, 0,            0, 0,    2});
        tbl.push_back('{1, 0, 1, 5, 0, 32'hB5,       1, 1, 2,  0, 0, 0, 0,            0, 0,            0, 0,    0});
        tbl.push_back('{0, 0, 0, 0, 0, 0,            1, 1, 2,  1, 0, 0, 0,            0, 0,            0, 0,    0});

        idle_inputs();
        reset = 1;
        @(posedge clk); #1;

        for (int k = 0; k < tbl.size(); k++) begin
            reset     = tbl[k].rst[0];
            flush     = tbl[k].fl[0];
            in_valid  = tbl[k].v[0];
            in_dst    = tbl[k].dst[4:0];
            jal_instr = tbl[k].jal[0];
            in_data   = tbl[k].data;
            drain     = tbl[k].dr[0];
            Rs        = tbl[k].rs[4:0];
            Rt        = tbl[k].rt[4:0];
            @(negedge clk);
            check($sformatf("v%0d.in_ready", k), {31'b0, in_ready}, tbl[k].rdy);
            check($sformatf("v%0d.regWr", k),    {31'b0, regWr},    tbl[k].wr);
            check($sformatf("v%0d.Rw", k),       {27'b0, Rw},       tbl[k].rw);
            check($sformatf("v%0d.busW", k),     busW,              tbl[k].bw);
            check($sformatf("v%0d.hitA", k),     {31'b0, hitA},     tbl[k].ha);
            check($sformatf("v%0d.fwdA", k),     fwdA,              tbl[k].fa);
            check($sformatf("v%0d.hitB", k),     {31'b0, hitB},     tbl[k].hb);
            check($sformatf("v%0d.fwdB", k),     fwdB,              tbl[k].fb);
            check($sformatf("v%0d.count", k),    {29'b0, count},    tbl[k].cnt);
            @(posedge clk); #1;
        end

        // Random push/drain traffic against a reference FIFO, wrapping pointers many times.
        idle_inputs();
        model.delete();
        for (int c = 0; c < 60; c++) begin
            logic        e_rdy, e_pop, e_ha, e_hb;
            logic [31:0] e_fa, e_fb;
            in_valid  = ($urandom_range(0, 9) < 8);
            in_dst    = 5'($urandom_range(0, 7));
            jal_instr = ($urandom_range(0, 9) == 0);
            in_data   = $urandom;
            drain     = ($urandom_range(0, 9) < 5);
            Rs        = 5'($urandom_range(0, 7));
            Rt        = 5'($urandom_range(0, 7));
            @(negedge clk);
            e_pop = drain && (model.size() != 0);
            e_rdy = (model.size() < DEPTH) || e_pop;
            e_ha = 0; e_hb = 0; e_fa = 0; e_fb = 0;
            for (int j = 0; j < model.size(); j++) begin
                if (Rs != 0 && model[j][36:32] == Rs) begin e_ha = 1; e_fa = model[j][31:0]; end
                if (Rt != 0 && model[j][36:32] == Rt) begin e_hb = 1; e_fb = model[j][31:0]; end
            end
            check($sformatf("r%0d.in_ready", c), {31'b0, in_ready}, {31'b0, e_rdy});
            check($sformatf("r%0d.regWr", c),    {31'b0, regWr},    {31'b0, e_pop});
            check($sformatf("r%0d.Rw", c),       {27'b0, Rw},       e_pop ? {27'b0, model[0][36:32]} : 32'd0);
            check($sformatf("r%0d.busW", c),     busW,              e_pop ? model[0][31:0] : 32'd0);
            check($sformatf("r%0d.count", c),    {29'b0, count},    model.size());
            check($sformatf("r%0d.hitA", c),     {31'b0, hitA},     {31'b0, e_ha});
            check($sformatf("r%0d.fwdA", c),     fwdA,              e_fa);
            check($sformatf("r%0d.hitB", c),     {31'b0, hitB},     {31'b0, e_hb});
            check($sformatf("r%0d.fwdB", c),     fwdB,              e_fb);
            if (e_pop) void'(model.pop_front());
            if (in_valid && e_rdy) begin
                logic [4:0] ed;
                ed = jal_instr ? 5'd31 : in_dst;
                if (ed != 0) model.push_back({ed, in_data});
            end
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gpr_wb_queue.md
# gpr_wb_queue

Write-back queue that owns the single register-file write port of the GPR file (`regWr`, `Rw`, `busW`). Upstream result producers (ALU, load path, `jal` link) hand results in through a valid/ready handshake. The queue buffers them in order and drains one write per cycle whenever the write port is granted. It also reports, and forwards data for, any register with a write still pending, so the decode stage can bypass or stall on `Rs`/`Rt`.

## Interface
- `DEPTH`, 4, number of entries; power of two, 2..16.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high; empties the queue.
- `flush`  in  1  synchronous discard of all entries (pipeline squash).
- `in_valid`  in  1  producer has a result.
- `in_ready`  out  1  queue accepts the result this cycle.
- `in_dst`  in  5  destination register.
- `jal_instr`  in  1  overrides the destination to 31.
- `in_data`  in  32  result value.
- `drain`  in  1  write port granted this cycle; the head may be written.
- `regWr`  out  1  register-file write enable.
- `Rw`  out  5  write address.
- `busW`  out  32  write data.
- `Rs`, `Rt`  in  5 each  decode-stage source registers.
- `hitA`, `hitB`  out  1 each  a pending write exists for `Rs` / `Rt`.
- `fwdA`, `fwdB`  out  32 each  data of the youngest pending write to `Rs` / `Rt`.
- `count`  out  clog2(DEPTH+1)  number of occupied entries.

## Operation
- Storage: circular buffer of DEPTH entries {dst[4:0], data[31:0]}, with head/tail pointers and an occupancy count. Pointers wrap modulo DEPTH.
- Effective destination: `edst = jal_instr ? 31 : in_dst`.
- Push: occurs when `in_valid && in_ready`.
  - If `edst == 0`, the handshake completes but nothing is stored (register 0 is never written).
  - Otherwise `{edst, in_data}` is written at the tail.
- `in_ready = !flush && (count < DEPTH || (drain && count != 0))`, so a full queue accepts a new result in the same cycle that it pops.
- Pop: occurs when `drain && count != 0 && !flush`.
  - `regWr = 1`, `Rw = head.dst`, `busW = head.data`, all combinational from the head in that cycle.
  - The head advances at the clock edge.
- Outside a pop: `regWr = 0`, `Rw = 0`, `busW = 0`.
- Simultaneous push and pop: `count` is unchanged, and both pointers advance.
- Hazard lookup: fully combinational, over all occupied entries including the head being popped this cycle.
  - `hitA = (Rs != 0) && ∃ entry with dst == Rs`.
  - `fwdA` = data of the youngest such entry (closest to the tail); `fwdA = 0` when `hitA = 0`. `B` is identical using `Rt`.
  - The incoming (not yet stored) result is not visible to the lookup.
- Flush: at the next edge, `count = 0` and `head = tail = 0`.
  - In the flush cycle, `in_ready = 0` and `regWr = 0`.
  - A result presented during flush is dropped.
- Reset: same effect as flush and takes priority over it. `count = 0`, pointers 0, and every output reads 0 (`hitA/B = 0`, `regWr = 0`, `in_ready = 0` while `reset` is high).

## Timing
- Result accepted at edge N with the queue empty and `drain` high: `regWr = 1` in cycle N..N+1, so the GPR file commits at edge N+1. Minimum latency is one cycle.
- Throughput: one push and one write per cycle sustained.
- Handshake rules:
  - The producer holds `in_dst`, `jal_instr` and `in_data` stable while `in_valid && !in_ready`.
  - `in_valid` may drop without the handshake completing.
- `drain` low for k cycles: no write, `count` grows, and at DEPTH entries `in_ready = 0` until `drain` returns.
- Writes leave strictly in push order. Two pending writes to the same register commit in order, and the lookup returns the newer value.
- Reset or flush in the middle of a drain discards the remaining entries. No partial write occurs in that cycle.
- `count` never exceeds DEPTH. An overflow assertion must never fire.

## Test plan
- **Reset then single result.** Reset 2 cycles, then push dst 5 with data 0xDEADBEEF and `drain` = 1. Required: `regWr = 1`, `Rw = 5`, `busW = 0xDEADBEEF` for exactly one cycle, and `count` returns to 0.
- **Backpressure.** Hold `drain` = 0 and push 5 results with DEPTH = 4. Required: the 5th sees `in_ready = 0` with `count = 4`. Raise `drain`: the 5th is accepted in the same cycle as the first pop, and writes emerge in order 1..5.
- **Forwarding youngest.** With `drain` = 0, push r7 = 0x11, then r7 = 0x22, then r3 = 0x33. Set `Rs` = 7, `Rt` = 3. Required: `hitA = 1`, `fwdA = 0x22`, `hitB = 1`, `fwdB = 0x33`. With `Rs` = 0: `hitA = 0`.
- **r0 and jal.** Push `in_dst` = 0 with `jal_instr` = 0: the handshake completes, `count` stays 0, and there is no write. Push `in_dst` = 4 with `jal_instr` = 1 and data 0x400010: required `Rw = 31`, `busW = 0x400010`.
- **Flush and reset mid-operation.** Queue 3 entries, then assert `flush` with `in_valid` = 1. Required: `in_ready = 0` and `regWr = 0` that cycle, then `count = 0` and no later writes. Repeat with `reset` and `drain` = 1: same result.
- **Pointer wrap.** Run 20 random push/drain cycles at DEPTH = 4. Required: write sequence matches a reference FIFO model across multiple pointer wraps.
